// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the Hack-style multicycle control unit:
//   FSM state encoding and instruction field bit positions.
//   Instruction layout (16-bit):
//     A-instr : bit15 = 0, bits 14:0 = immediate
//     C-instr : bit15 = 1, bits 14:13 ignored, [12]=a, [11:6]=zx,nx,zy,ny,f,no,
//               [5:3]=dA,dD,dM, [2:0]=jLT,jEQ,jGT
// -----------------------------------------------------------------------------
package cpu_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_MEM_RD = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM_WR = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam int C_BIT    = 15;  // 1 = C-instruction
   localparam int A_BIT    = 12;  // ALU y operand select (A / M)
   localparam int COMP_MSB = 11;  // zx
   localparam int COMP_LSB = 6;   // no
   localparam int DEST_A   = 5;
   localparam int DEST_D   = 4;
   localparam int DEST_M   = 3;
   localparam int JMP_LT   = 2;
   localparam int JMP_EQ   = 1;
   localparam int JMP_GT   = 0;

   // Jump condition from the three jump bits and the ALU flags.
   function automatic logic jump_taken(input logic [2:0] jmp,
                                       input logic       zr,
                                       input logic       ng);
      return (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
   endfunction

endpackage

// File: rtl/cpu_control_program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
//   Holds the instruction address. Load has priority over increment; the
//   increment wraps modulo 2**PC_W.
//   Ports:
//     clk, rst   clock / synchronous active-high reset (pc -> 0)
//     inc        advance pc by one
//     load       replace pc with load_val
//     load_val   jump target
//     pc         current program counter
// -----------------------------------------------------------------------------
module program_counter #(
   parameter int PC_W = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inc,
   input  logic            load,
   input  logic [PC_W-1:0] load_val,
   output logic [PC_W-1:0] pc
);

   logic [PC_W-1:0] pc_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg <= '0;
      end else if (load) begin
         pc_reg <= load_val;
      end else if (inc) begin
         pc_reg <= pc_reg + PC_W'(1);
      end
   end

   assign pc = pc_reg;

endmodule

// File: rtl/cpu_control.sv
// -----------------------------------------------------------------------------
// cpu_control
//   Multicycle control unit for a 16-bit Hack-style CPU. Fetches from the
//   instruction ROM, decodes A/C instructions, drives the ALU control lines,
//   sequences data-memory read/write handshakes and owns the program counter.
//
//   Optional feature: define HALT_DETECT_EN to stop the CPU when a taken jump
//   targets its own address (halted=1, no further requests until rst).
//   Without it, halted is tied 0 and such a loop simply re-fetches forever.
//
//   Ports:
//     clk, rst             clock / synchronous active-high reset
//     imem_addr/req        instruction fetch address (= pc) and request
//     imem_ack/data        fetch completion and instruction word
//     dmem_req/we          data access request (address is datapath A),
//                          we=1 writes the ALU result to M
//     dmem_ack             data access completes this cycle
//     a_value              current A register (jump target / halt compare)
//     imm                  latched instruction (A-instr immediate)
//     a_sel                A source: 0 = imm, 1 = ALU result
//     a_load, d_load       A / D register write strobes
//     m_latch              datapath captures read M data
//     am_sel               ALU y operand: 0 = A, 1 = M
//     zx,nx,zy,ny,f,no     ALU controls
//     alu_zr, alu_ng       ALU flags
//     halted               CPU halted
// -----------------------------------------------------------------------------
module cpu_control
   import cpu_pkg::*;
#(
   parameter int PC_W   = 15,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   output logic [PC_W-1:0]   imem_addr,
   output logic              imem_req,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_data,
   output logic              dmem_req,
   output logic              dmem_we,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] a_value,
   output logic [DATA_W-1:0] imm,
   output logic              a_sel,
   output logic              a_load,
   output logic              d_load,
   output logic              m_latch,
   output logic              am_sel,
   output logic              zx,
   output logic              nx,
   output logic              zy,
   output logic              ny,
   output logic              f,
   output logic              no,
   input  logic              alu_zr,
   input  logic              alu_ng,
   output logic              halted
);

   state_t            state_reg, state_next;
   logic [DATA_W-1:0] instr_reg;
   logic              take_reg;

   logic [PC_W-1:0]   pc;
   logic              pc_inc, pc_load;
   logic              take_now, take_commit, commit;
   logic [PC_W-1:0]   jump_target;

   // Only the low PC_W bits of A address instruction memory.
   logic              unused_a_bits;
   assign unused_a_bits = ^a_value[DATA_W-1:PC_W];

   assign jump_target = a_value[PC_W-1:0];
   assign take_now    = jump_taken(instr_reg[JMP_LT:JMP_GT], alu_zr, alu_ng);
   // In EXEC the flags are live; in MEM_WR they may have moved on, so the
   // decision captured in EXEC is used instead.
   assign take_commit = (state_reg == S_EXEC) ? take_now : take_reg;

   program_counter #(.PC_W(PC_W)) u_pc (
      .clk      (clk),
      .rst      (rst),
      .inc      (pc_inc),
      .load     (pc_load),
      .load_val (jump_target),
      .pc       (pc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_FETCH;
         instr_reg <= '0;
         take_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_FETCH && imem_ack) begin
            instr_reg <= imem_data;
         end
         if (state_reg == S_EXEC) begin
            take_reg <= take_now;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      imem_addr  = pc;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      imm        = instr_reg;
      a_sel      = 1'b0;
      a_load     = 1'b0;
      d_load     = 1'b0;
      m_latch    = 1'b0;
      am_sel     = 1'b0;
      zx         = 1'b0;
      nx         = 1'b0;
      zy         = 1'b0;
      ny         = 1'b0;
      f          = 1'b0;
      no         = 1'b0;
      halted     = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      commit     = 1'b0;

      case (state_reg)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               state_next = S_DECODE;
            end
         end

         S_DECODE: begin
            if (!instr_reg[C_BIT]) begin
               a_sel      = 1'b0;
               a_load     = 1'b1;
               pc_inc     = 1'b1;
               state_next = S_FETCH;
            end else if (instr_reg[A_BIT]) begin
               state_next = S_MEM_RD;
            end else begin
               state_next = S_EXEC;
            end
         end

         S_MEM_RD: begin
            dmem_req = 1'b1;
            if (dmem_ack) begin
               m_latch    = 1'b1;
               state_next = S_EXEC;
            end
         end

         S_EXEC: begin
            am_sel                 = instr_reg[A_BIT];
            {zx, nx, zy, ny, f, no} = instr_reg[COMP_MSB:COMP_LSB];
            if (instr_reg[DEST_M]) begin
               state_next = S_MEM_WR;
            end else begin
               commit = 1'b1;
            end
         end

         S_MEM_WR: begin
            // ALU controls held so the write data stays valid until ack.
            am_sel                 = instr_reg[A_BIT];
            {zx, nx, zy, ny, f, no} = instr_reg[COMP_MSB:COMP_LSB];
            dmem_req = 1'b1;
            dmem_we  = 1'b1;
            if (dmem_ack) begin
               commit = 1'b1;
            end
         end

         S_HALT: begin
`ifdef HALT_DETECT_EN
            halted = 1'b1;
`endif
         end

         default: begin
            state_next = S_FETCH;
         end
      endcase

      // Commit: register loads and PC update all happen together, so the
      // M address and jump target both see the pre-update A.
      if (commit) begin
         a_sel      = 1'b1;
         a_load     = instr_reg[DEST_A];
         d_load     = instr_reg[DEST_D];
         pc_load    = take_commit;
         pc_inc     = ~take_commit;
         state_next = S_FETCH;
`ifdef HALT_DETECT_EN
         if (take_commit && (jump_target == pc)) begin
            state_next = S_HALT;
         end
`endif
      end

      // Reset overrides everything, including a same-cycle ack.
      if (rst) begin
         imem_addr = '0;
         imem_req  = 1'b0;
         dmem_req  = 1'b0;
         dmem_we   = 1'b0;
         imm       = '0;
         a_sel     = 1'b0;
         a_load    = 1'b0;
         d_load    = 1'b0;
         m_latch   = 1'b0;
         am_sel    = 1'b0;
         zx        = 1'b0;
         nx        = 1'b0;
         zy        = 1'b0;
         ny        = 1'b0;
         f         = 1'b0;
         no        = 1'b0;
         halted    = 1'b0;
         pc_inc    = 1'b0;
         pc_load   = 1'b0;
      end
   end

endmodule
